// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD counter run/stop sequencer and
// display scanner.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    CLEARING = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_seg_decoder.sv
// BCD to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
// Codes 10..15 are not valid BCD and render as a dash.
module bcd_seg_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_counter_scan_ctrl.sv
// Run/stop/clear sequencer for the 4-digit BCD counter plus a
// time-multiplexed 7-segment scanner with optional leading-zero blanking.
module bcd_counter_scan_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       blank_lz,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  output logic       count_tick,
  output logic       counter_rst,
  output logic       running,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  state_t        state, state_nxt;
  logic [TW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  digit_idx_t    idx;
  logic          presc_wrap;
  logic          scan_wrap;
  logic [3:0]    digit_sel;
  logic          blank_sel;
  logic [6:0]    seg_dec;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_nxt;
  end

  // clear beats stop beats start; a start paired with stop never runs
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = CLEARING;
    end else begin
      case (state)
        STOPPED:  if (start && !stop) state_nxt = RUNNING;
        RUNNING:  if (stop) state_nxt = STOPPED;
        CLEARING: state_nxt = STOPPED;
        default:  state_nxt = STOPPED;
      endcase
    end
  end

  assign running    = (state == RUNNING);
  assign presc_wrap = (state == RUNNING) && (presc == TW'(TICK_DIV - 1));

  // Prescaler holds while stopped so a pause/resume keeps tick phase.
  // counter_rst resets high so the counter sees one clearing edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      count_tick  <= 1'b0;
      counter_rst <= 1'b1;
    end else begin
      counter_rst <= (state_nxt == CLEARING);
      count_tick  <= presc_wrap && !stop && !clear;
      if (state == CLEARING)
        presc <= '0;
      else if (state == RUNNING)
        presc <= presc_wrap ? '0 : presc + TW'(1);
    end
  end

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap) idx <= idx + 2'd1;
    end
  end

  // A digit is a leading zero when it and every higher digit are zero
  always_comb begin
    digit_sel = units;
    blank_sel = 1'b0;
    case (idx)
      2'd0: digit_sel = units;
      2'd1: begin
        digit_sel = tens;
        blank_sel = blank_lz && (thousands == 4'd0) && (hundreds == 4'd0) && (tens == 4'd0);
      end
      2'd2: begin
        digit_sel = hundreds;
        blank_sel = blank_lz && (thousands == 4'd0) && (hundreds == 4'd0);
      end
      2'd3: begin
        digit_sel = thousands;
        blank_sel = blank_lz && (thousands == 4'd0);
      end
      default: digit_sel = units;
    endcase
    an_nxt  = ~(4'b0001 << idx);
    seg_nxt = seg_dec;
    if (blank_sel) begin
      an_nxt  = 4'b1111;
      seg_nxt = SEG_BLANK;
    end
  end

  bcd_seg_decoder u_dec (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_counter_scan_ctrl.sv
// Scoreboard bench: a behavioural model queues the expected outputs for every
// clock edge and a monitor pops and compares them just after the edge.
module tb_bcd_counter_scan_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  typedef struct packed {
    logic       tick;
    logic       crst;
    logic       run;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst;
  logic       start, stop, clear, blank_lz;
  logic [3:0] units, tens, hundreds, thousands;
  logic       count_tick, counter_rst, running;
  logic [3:0] an;
  logic [6:0] seg;

  int   errors = 0;
  int   checks = 0;
  exp_t expQ[$];

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // mode: 0 = stopped, 1 = running, 2 = clearing
  int         mMode, mPhase, mIdx, mScan, mTop, mNext;
  logic [3:0] mDig [4];
  exp_t       mExp;

  bcd_counter_scan_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clock       (clock),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .blank_lz    (blank_lz),
    .units       (units),
    .tens        (tens),
    .hundreds    (hundreds),
    .thousands   (thousands),
    .count_tick  (count_tick),
    .counter_rst (counter_rst),
    .running     (running),
    .an          (an),
    .seg         (seg)
  );

  always #5 clock = ~clock;

  always @(posedge rst) begin
    mMode = 0; mPhase = 0; mIdx = 0; mScan = 0;
  end

  // Reference model: one step per clock edge, expected result queued
  always @(posedge clock) begin
    if (rst) begin
      mMode = 0; mPhase = 0; mIdx = 0; mScan = 0;
      mExp = '{tick: 1'b0, crst: 1'b1, run: 1'b0, an: 4'hF, seg: 7'h7F};
    end else begin
      mDig[0] = units; mDig[1] = tens; mDig[2] = hundreds; mDig[3] = thousands;
      mTop = 0;
      for (int k = 1; k < 4; k++) if (mDig[k] != 4'd0) mTop = k;
      if (blank_lz && mIdx > mTop) begin
        mExp.an  = 4'hF;
        mExp.seg = 7'h7F;
      end else begin
        mExp.an  = 4'hF & ~(4'(1) << mIdx);
        mExp.seg = segTable[mDig[mIdx]];
      end
      mExp.tick = (mMode == 1) && (mPhase == TICK_DIV - 1) && !stop && !clear;
      if (clear)           mNext = 2;
      else if (mMode == 1) mNext = stop ? 0 : 1;
      else if (mMode == 0) mNext = (start && !stop) ? 1 : 0;
      else                 mNext = 0;
      if (mMode == 2)      mPhase = 0;
      else if (mMode == 1) mPhase = (mPhase + 1) % TICK_DIV;
      mMode     = mNext;
      mExp.crst = (mMode == 2);
      mExp.run  = (mMode == 1);
      mScan = (mScan + 1) % SCAN_DIV;
      if (mScan == 0) mIdx = (mIdx + 1) % 4;
    end
    expQ.push_back(mExp);
  end

  always @(posedge clock) begin
    exp_t got, want;
    #1;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty at t=%0t", $time);
    end else begin
      want = expQ.pop_front();
      got  = '{tick: count_tick, crst: counter_rst, run: running, an: an, seg: seg};
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL outputs t=%0t tick/crst/run/an/seg got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
                 $time, got.tick, got.crst, got.run, got.an, got.seg,
                 want.tick, want.crst, want.run, want.an, want.seg);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c, input int idle);
    @(negedge clock);
    start = s; stop = p; clear = c;
    @(negedge clock);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (idle) @(negedge clock);
  endtask

  task automatic setDigits(input logic [3:0] t, input logic [3:0] h, input logic [3:0] e,
                           input logic [3:0] u, input logic lz);
    thousands = t; hundreds = h; tens = e; units = u; blank_lz = lz;
  endtask

  initial begin
    logic [15:0] mask;
    int n, blanks, ticks;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    setDigits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("reset_values", {count_tick, counter_rst, running, an, seg},
                {1'b0, 1'b1, 1'b0, 4'hF, 7'h7F});

    // release reset with a start pulse sampled at edge 0
    rst = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("running_after_start", {running, counter_rst}, 2'b10);
    mask = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (count_tick) mask[i] = 1'b1;
    end
    checkOutput("tick_cycles", mask, 16'h1110);

    // stop lands when prescaler becomes 2; resume needs 2 more cycles
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    ticks = 0;
    repeat (10) begin
      @(negedge clock);
      if (count_tick) ticks++;
    end
    checkOutput("no_ticks_stopped", ticks, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!count_tick && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("resume_latency", n, 2);

    // clear with start and stop while running
    repeat (2) @(negedge clock);
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    checkOutput("clear_cycle", {counter_rst, running, count_tick}, 3'b100);
    @(negedge clock);
    checkOutput("after_clear", {counter_rst, running, count_tick}, 3'b000);
    repeat (6) @(negedge clock);

    // leading-zero blanking: two of four slots dark
    setDigits(4'd0, 4'd0, 4'd4, 4'd7, 1'b1);
    @(negedge clock);
    blanks = 0;
    repeat (8) begin
      @(negedge clock);
      if (an == 4'hF) blanks++;
    end
    checkOutput("blank_slots_lz1", blanks, 4);
    blank_lz = 1'b0;
    @(negedge clock);
    blanks = 0;
    repeat (8) begin
      @(negedge clock);
      if (an == 4'hF) blanks++;
    end
    checkOutput("blank_slots_lz0", blanks, 0);
    units = 4'hC;
    repeat (8) @(negedge clock);

    // asynchronous reset between ticks
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", {count_tick, counter_rst, running, an, seg},
                   {1'b0, 1'b1, 1'b0, 4'hF, 7'h7F});
    repeat (2) @(negedge clock);
    rst = 1'b0;
    ticks = 0;
    repeat (10) begin
      @(negedge clock);
      if (count_tick) ticks++;
    end
    checkOutput("no_tick_after_reset", ticks, 0);

    // randomized traffic, scoreboard only
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) begin
        thousands = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        hundreds  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        tens      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        units     = 4'($urandom_range(0, 15));
        blank_lz  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clock);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
